// File: rtl/lsu.sv
// rtl/lsu.sv - RV32I load/store unit with valid/ready data-memory bus
//
// Purpose: takes the ALU result as the effective address and runs one
// data-memory access per load/store. It builds byte enables and lane-aligned
// store data, and sign- or zero-extends load data. It stalls the core while
// the access is in flight.
//
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   mem_read, mem_write    current instruction is a load / store
//   funct3                 width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   addr, wdata            effective address, store data (rs2)
//   stall                  hold PC and suppress writeback
//   load_data, done, fault extended load result, completion pulse, fault code
//   dmem_*                 data-memory request/response bus
module lsu #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_W          = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic [31:0] load_data,
   output logic        done,
   output logic [1:0]  fault,
   output logic        dmem_valid,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ready,
   input  logic [31:0] dmem_rdata
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   localparam logic [1:0] F_NONE     = 2'b00;
   localparam logic [1:0] F_MISALIGN = 2'b01;
   localparam logic [1:0] F_TIMEOUT  = 2'b10;
   localparam logic [1:0] F_ILLEGAL  = 2'b11;

   // Counter value seen in the last REQ cycle that may still wait for ready.
   localparam logic [CNT_W-1:0] TO_LAST =
      (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);
   localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             valid_q, valid_d;
   logic             we_q, we_d;
   logic [31:0]      addr_q, addr_d;
   logic [3:0]       be_q, be_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [31:0]      ld_q, ld_d;
   logic             done_q, done_d;
   logic [1:0]       fault_q, fault_d;
   logic [1:0]       off_q, off_d;
   logic [2:0]       f3_q, f3_d;

   logic        is_rd, is_wr, illegal, misaligned;
   logic [3:0]  req_be;
   logic [31:0] req_wdata;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;
   logic [31:0] rd_fmt;
   logic        timeout_hit;

   // Request decode, evaluated on the live inputs in IDLE.
   always_comb begin
      is_rd      = mem_read & ~mem_write;
      is_wr      = mem_write & ~mem_read;
      illegal    = (mem_read & mem_write)
                 | (is_rd & ((funct3 == 3'b011) | (funct3 == 3'b110) | (funct3 == 3'b111)))
                 | (is_wr & (funct3[2] | (funct3[1:0] == 2'b11)));
      misaligned = ((funct3[1:0] == 2'b01) & addr[0])
                 | ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
      req_be    = 4'b1111;
      req_wdata = wdata;
      case (funct3[1:0])
         2'b00: begin
            req_be    = 4'b0001 << addr[1:0];
            req_wdata = {4{wdata[7:0]}};
         end
         2'b01: begin
            req_be    = addr[1] ? 4'b1100 : 4'b0011;
            req_wdata = {2{wdata[15:0]}};
         end
         default: ;
      endcase
   end

   // Load extraction uses the latched offset/funct3; the bus address is word-aligned.
   always_comb begin
      rd_byte = 8'(dmem_rdata >> {off_q, 3'b000});
      rd_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (f3_q)
         3'b000:  rd_fmt = {{24{rd_byte[7]}}, rd_byte};
         3'b001:  rd_fmt = {{16{rd_half[15]}}, rd_half};
         3'b100:  rd_fmt = {24'd0, rd_byte};
         3'b101:  rd_fmt = {16'd0, rd_half};
         default: rd_fmt = dmem_rdata;
      endcase
   end

   assign timeout_hit = TO_EN && (cnt_q == TO_LAST);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      we_d    = we_q;
      addr_d  = addr_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      ld_d    = ld_q;
      done_d  = 1'b0;
      fault_d = fault_q;
      off_d   = off_q;
      f3_d    = f3_q;
      case (state_q)
         S_IDLE: begin
            if (mem_read | mem_write) begin
               if (illegal | misaligned) begin
                  // Faulting requests never touch the bus.
                  state_d = S_RESP;
                  done_d  = 1'b1;
                  fault_d = illegal ? F_ILLEGAL : F_MISALIGN;
                  ld_d    = '0;
               end else begin
                  state_d = S_REQ;
                  cnt_d   = '0;
                  valid_d = 1'b1;
                  we_d    = mem_write;
                  addr_d  = {addr[31:2], 2'b00};
                  be_d    = req_be;
                  wdata_d = req_wdata;
                  off_d   = addr[1:0];
                  f3_d    = funct3;
               end
            end
         end
         S_REQ: begin
            // Ready is checked first so it wins over a coincident timeout.
            if (dmem_ready) begin
               state_d = S_RESP;
               valid_d = 1'b0;
               done_d  = 1'b1;
               fault_d = F_NONE;
               if (!we_q) ld_d = rd_fmt;
            end else if (timeout_hit) begin
               state_d = S_RESP;
               valid_d = 1'b0;
               done_d  = 1'b1;
               fault_d = F_TIMEOUT;
               ld_d    = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         ld_q    <= '0;
         done_q  <= 1'b0;
         fault_q <= F_NONE;
         off_q   <= '0;
         f3_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         ld_q    <= ld_d;
         done_q  <= done_d;
         fault_q <= fault_d;
         off_q   <= off_d;
         f3_q    <= f3_d;
      end
   end

   assign stall      = ((state_q == S_IDLE) && (mem_read || mem_write)) || (state_q == S_REQ);
   assign load_data  = ld_q;
   assign done       = done_q;
   assign fault      = fault_q;
   assign dmem_valid = valid_q;
   assign dmem_we    = we_q;
   assign dmem_addr  = addr_q;
   assign dmem_be    = be_q;
   assign dmem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - self-checking bench for lsu
module tb_lsu;

   localparam int TB_TO = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mem_read = 1'b0, mem_write = 1'b0;
   logic [2:0]  funct3 = '0;
   logic [31:0] addr = '0, wdata = '0;
   logic        stall, done, dmem_valid, dmem_we;
   logic [31:0] load_data, dmem_addr, dmem_wdata;
   logic [1:0]  fault;
   logic [3:0]  dmem_be;
   logic        dmem_ready = 1'b0;
   logic [31:0] dmem_rdata = '0;

   lsu #(.TIMEOUT_CYCLES(TB_TO), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
      .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall),
      .load_data(load_data), .done(done), .fault(fault),
      .dmem_valid(dmem_valid), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
      .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        stall, valid, we, done;
      logic [31:0] addr, wdata, ld;
      logic [3:0]  be;
      logic [1:0]  fault;
   } exp_t;

   exp_t exp_q[$];
   int   pass_cnt = 0, total_cnt = 0, cyc = 0;
   logic [1:0]  exp_f = '0;
   logic [31:0] exp_ld = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total_cnt++;
      if (act === req) pass_cnt++;
      else $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, req);
   endtask

   // Transaction-level model: result of one access from the ISA rules.
   task automatic model_req(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                            output logic [1:0] flt, output logic [3:0] be,
                            output logic [31:0] lane, output logic [31:0] res);
      int nb;
      logic [31:0] v;
      bit legal;
      nb = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      if (rd && !wr)      legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
      else if (wr && !rd) legal = (f3 == 0 || f3 == 1 || f3 == 2);
      else                legal = 0;
      if (!legal)                flt = 2'b11;
      else if (a % nb != 0)      flt = 2'b01;
      else                       flt = 2'b00;
      be = 4'(((1 << nb) - 1) << (a % 4));
      if (nb == 1)      lane = (wd & 32'hFF) * 32'h0101_0101;
      else if (nb == 2) lane = (wd & 32'hFFFF) * 32'h0001_0001;
      else              lane = wd;
      if (nb == 4) res = rdat;
      else begin
         v = (rdat >> (8 * (a % 4))) & ((32'd1 << (8 * nb)) - 1);
         if (!f3[2] && v >= (32'd1 << (8 * nb - 1))) v = v - (32'd1 << (8 * nb));
         res = v;
      end
   endtask

   function automatic exp_t mk(input logic s, input logic v, input logic we,
                               input logic [31:0] a, input logic [3:0] be,
                               input logic [31:0] wd, input logic d);
      exp_t e;
      e.stall = s; e.valid = v; e.we = we; e.addr = a; e.be = be; e.wdata = wd;
      e.done = d; e.fault = exp_f; e.ld = exp_ld;
      return e;
   endfunction

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         mem_read = 0; mem_write = 0; dmem_ready = 0;
         exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
      end
   endtask

   task automatic run_txn(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int waits, input logic [31:0] rdat);
      logic [1:0] flt; logic [3:0] be; logic [31:0] lane, res;
      int nreq;
      model_req(rd, wr, f3, a, wd, rdat, flt, be, lane, res);
      @(posedge clk); #1;
      mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd; dmem_ready = 0;
      exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0));
      if (flt != 2'b00) begin
         @(posedge clk); #1;
         mem_read = 0; mem_write = 0;
         exp_f = flt; exp_ld = 0;
         exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1));
      end else begin
         nreq = (waits < TB_TO) ? waits + 1 : TB_TO;
         for (int i = 0; i < nreq; i++) begin
            @(posedge clk); #1;
            dmem_ready = (i == waits);
            dmem_rdata = (i == waits) ? rdat : (32'h5A5A_0000 + 32'(i));
            exp_q.push_back(mk(1, 1, wr, {a[31:2], 2'b00}, be, lane, 0));
         end
         @(posedge clk); #1;
         mem_read = 0; mem_write = 0; dmem_ready = 0; dmem_rdata = 32'h0BAD_0BAD;
         if (waits >= TB_TO) begin exp_f = 2'b10; exp_ld = 0; end
         else begin exp_f = 2'b00; if (rd) exp_ld = res; end
         exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1));
      end
   endtask

   // Per-cycle compare against the model's expectations.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("stall", 32'(stall), 32'(e.stall));
            check("dmem_valid", 32'(dmem_valid), 32'(e.valid));
            check("done", 32'(done), 32'(e.done));
            check("fault", 32'(fault), 32'(e.fault));
            check("load_data", load_data, e.ld);
            if (e.valid) begin
               check("dmem_we", 32'(dmem_we), 32'(e.we));
               check("dmem_addr", dmem_addr, e.addr);
               check("dmem_be", 32'(dmem_be), 32'(e.be));
               check("dmem_wdata", dmem_wdata, e.wdata);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] f; logic [3:0] b; logic [31:0] l, r;
      // Hand-computed pins on the model itself.
      model_req(0, 1, 3'b000, 32'h103, 32'hA5, 0, f, b, l, r);
      check("pin_sb_be", 32'(b), 32'h8);
      check("pin_sb_lane", l, 32'hA5A5A5A5);
      model_req(1, 0, 3'b000, 32'h103, 0, 32'h80FF7F01, f, b, l, r);
      check("pin_lb", r, 32'hFFFFFF80);
      model_req(1, 0, 3'b100, 32'h103, 0, 32'h80FF7F01, f, b, l, r);
      check("pin_lbu", r, 32'h00000080);
      model_req(1, 0, 3'b001, 32'h102, 0, 32'h80011234, f, b, l, r);
      check("pin_lh", r, 32'hFFFF8001);
      check("pin_lh_be", 32'(b), 32'hC);
      model_req(1, 0, 3'b010, 32'h101, 0, 0, f, b, l, r);
      check("pin_lw_mis", 32'(f), 32'h1);
      model_req(0, 1, 3'b100, 32'h100, 0, 0, f, b, l, r);
      check("pin_sh_ill", 32'(f), 32'h3);

      // Reset state while rst_n is held low.
      @(posedge clk); #1;
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
      @(posedge clk); #1;
      rst_n = 1;
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
      idle(1);

      run_txn(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0);          // SW
      run_txn(0, 1, 3'b000, 32'h103, 32'h000000A5, 0, 0);          // SB lane 3
      run_txn(1, 0, 3'b000, 32'h103, 0, 0, 32'h80FF7F01);          // LB
      run_txn(1, 0, 3'b100, 32'h103, 0, 0, 32'h80FF7F01);          // LBU
      run_txn(1, 0, 3'b001, 32'h102, 0, 3, 32'h80011234);          // LH, 3 waits
      idle(1);
      run_txn(1, 0, 3'b101, 32'h100, 0, 1, 32'h1234F00D);          // LHU low half
      run_txn(0, 1, 3'b001, 32'h102, 32'hCAFE8765, 2, 0);          // SH upper
      run_txn(1, 0, 3'b000, 32'h101, 0, 0, 32'h00007F00);          // LB positive
      run_txn(1, 0, 3'b010, 32'h101, 0, 0, 0);                     // LW misaligned
      run_txn(0, 1, 3'b100, 32'h100, 32'h1, 0, 0);                 // SH funct3=100 illegal
      run_txn(1, 1, 3'b010, 32'h100, 32'h1, 0, 0);                 // both high
      run_txn(1, 0, 3'b001, 32'h103, 0, 0, 0);                     // LH misaligned
      run_txn(1, 0, 3'b011, 32'h100, 0, 0, 0);                     // load funct3=011
      run_txn(1, 0, 3'b010, 32'h200, 0, 99, 32'h11111111);         // timeout
      run_txn(1, 0, 3'b010, 32'h204, 0, 3, 32'hCAFEF00D);          // ready on 4th cycle
      idle(1);

      // Reset in the middle of REQ.
      @(posedge clk); #1;
      mem_write = 1; funct3 = 3'b010; addr = 32'h300; wdata = 32'h12345678;
      exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0));
      @(posedge clk); #1;
      exp_q.push_back(mk(1, 1, 1, 32'h300, 4'hF, 32'h12345678, 0));
      @(posedge clk); #1;
      mem_write = 0;
      #1 rst_n = 0;
      #1;
      check("rst_async_valid", 32'(dmem_valid), 32'h0);
      check("rst_async_done", 32'(done), 32'h0);
      exp_f = 0; exp_ld = 0;
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
      @(posedge clk); #1;
      rst_n = 1;
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
      run_txn(1, 0, 3'b010, 32'h300, 0, 0, 32'h89ABCDEF);
      idle(2);

      @(negedge clk);
      @(negedge clk);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
